fifo_push_arbiter: RTL and testbench

Round-robin push arbiter and occupancy controller that shares one `fifo_flops` instance between `n_req` producers. Each cycle it grants at most one requester and registers that requester's word onto the FIFO push port. It tracks FIFO occupancy with its own credit counter, so a grant is never issued that could overflow the FIFO. It sits directly in front of the FIFO's `Din`/`push` inputs; the consumer's `pop` is mirrored into the block.

---
 rtl/fifo_push_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: shares one fifo_flops instance between n_req producers.
// Each cycle at most one requester is granted (combinational gnt) and its word
// is registered onto the FIFO push port one cycle later. A local credit counter
// (occupancy) is charged at grant time, so the in-flight push can never
// overflow the FIFO. A pop in the same cycle frees a slot, so a producer
// blocked at credit_full is granted in the cycle the pop is seen.
//
// Build option:
//   FIFO_PUSH_ARB_FIXED_PRIO_EN defined  -> fixed priority, lowest index wins,
//                                           no round-robin pointer.
//   FIFO_PUSH_ARB_FIXED_PRIO_EN undefined -> round robin (default).
module fifo_push_arbiter #(
    parameter int n_req = 4,
    parameter int depth = 16,
    parameter int bits  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [n_req-1:0]             req,
    input  logic [n_req*bits-1:0]        din,
    input  logic                         pop,
    output logic [n_req-1:0]             gnt,
    output logic                         fifo_push,
    output logic [bits-1:0]              fifo_din,
    output logic [$clog2(depth+1)-1:0]   occupancy,
    output logic                         credit_full
);

    localparam int IDX_W = (n_req > 1) ? $clog2(n_req) : 1;
    localparam int OCC_W = $clog2(depth + 1);

    logic [IDX_W-1:0] base_s;
    logic             eligible_s;
    logic             grant_valid_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic [n_req-1:0] gnt_s;
    logic [bits-1:0]  data_sel_s;
    int               search_pos_s;
    logic [IDX_W-1:0] search_idx_s;
    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_next_s;
    logic             push_r;
    logic [bits-1:0]  din_r;
    logic             full_r;

`ifdef FIFO_PUSH_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always starts at index 0.
    assign base_s = '0;
`else
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_next_s;

    assign base_s = ptr_r;

    // Next pointer is one past the granted index, wrapping at n_req.
    always_comb begin
        ptr_next_s = ptr_r;
        if (!grant_valid_s) begin
            ptr_next_s = ptr_r;
        end else if (grant_idx_s == IDX_W'(n_req - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_idx_s + IDX_W'(1);
        end
    end

    // Round-robin pointer register; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_next_s;
        end
    end
`endif

    // A slot is available if credit remains or a pop frees one this cycle.
    assign eligible_s = !rst && ((occ_r < OCC_W'(depth)) || pop);

    // Circular search from base_s; first requester found wins.
    always_comb begin
        gnt_s         = '0;
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        data_sel_s    = '0;
        search_pos_s  = 0;
        search_idx_s  = '0;
        for (int i = 0; i < n_req; i++) begin
            search_pos_s = int'(base_s) + i;
            if (search_pos_s >= n_req) begin
                search_pos_s = search_pos_s - n_req;
            end else begin
                search_pos_s = search_pos_s;
            end
            search_idx_s = IDX_W'(search_pos_s);
            if (eligible_s && !grant_valid_s && req[search_idx_s]) begin
                grant_valid_s       = 1'b1;
                grant_idx_s         = search_idx_s;
                gnt_s[search_idx_s] = 1'b1;
                data_sel_s          = din[search_idx_s*bits +: bits];
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Credit update: grant charges, pop refunds, both together cancel.
    always_comb begin
        occ_next_s = occ_r;
        case ({grant_valid_s, pop})
            2'b10: occ_next_s = occ_r + OCC_W'(1);
            2'b01: begin
                if (occ_r != '0) begin
                    occ_next_s = occ_r - OCC_W'(1);
                end else begin
                    occ_next_s = occ_r;
                end
            end
            default: occ_next_s = occ_r;
        endcase
    end

    // Push register, credit counter and full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_r <= 1'b0;
            din_r  <= '0;
            occ_r  <= '0;
            full_r <= 1'b0;
        end else begin
            if (grant_valid_s) begin
                push_r <= 1'b1;
                din_r  <= data_sel_s;
            end else begin
                push_r <= 1'b0;
            end
            occ_r  <= occ_next_s;
            full_r <= (occ_next_s == OCC_W'(depth));
        end
    end

    assign gnt         = gnt_s;
    assign fifo_push   = push_r;
    assign fifo_din    = din_r;
    assign occupancy   = occ_r;
    assign credit_full = full_r;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter (n_req=4, depth=16, bits=32):
// directed vector table, hand-written full / pop corner sequences, then
// randomized traffic compared against a queue-free arithmetic model.
module tb_fifo_push_arbiter;

    localparam int N = 4;
    localparam int D = 16;
    localparam int B = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*B-1:0] din;
    logic           pop;
    logic [N-1:0]   gnt;
    logic           fifo_push;
    logic [B-1:0]   fifo_din;
    logic [4:0]     occupancy;
    logic           credit_full;

    int total;
    int bad;

    fifo_push_arbiter #(.n_req(N), .depth(D), .bits(B)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .pop(pop),
        .gnt(gnt), .fifo_push(fifo_push), .fifo_din(fifo_din),
        .occupancy(occupancy), .credit_full(credit_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [3:0]   req;
        logic         pop;
        logic [3:0]   exp_gnt;
        logic         exp_push;
        logic [31:0]  exp_din;
        logic [4:0]   exp_occ;
        logic         exp_full;
    } vec_t;

    vec_t tv[11];

    function automatic logic [31:0] slot(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One directed cycle: check gnt mid-cycle, then the registered outputs.
    task automatic run_cycle(input logic r, input logic [3:0] rq, input logic p,
                             input logic [3:0] eg, input logic ep, input logic [31:0] ed,
                             input logic [4:0] eo, input logic ef, input string tag);
        rst = r; req = rq; pop = p;
        #4;
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        @(posedge clk); #1;
        check({tag, ".push"}, 32'(fifo_push), 32'(ep));
        check({tag, ".din"}, fifo_din, ed);
        check({tag, ".occ"}, 32'(occupancy), 32'(eo));
        check({tag, ".full"}, 32'(credit_full), 32'(ef));
    endtask

    // reference model state
    int m_occ, m_ptr, m_k;
    logic m_push;
    logic [31:0] m_din;
    logic [3:0] m_gnt;

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; req = '0; pop = 1'b0;
        for (int i = 0; i < N; i++) din[i*B +: B] = slot(i);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // rst req pop  gnt  push din      occ full
        tv[0]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 32'h0,   5'd0, 1'b0};
`ifdef FIFO_PUSH_ARB_FIXED_PRIO_EN
        tv[1]  = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b1, slot(0), 5'd1, 1'b0};
        tv[2]  = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b1, slot(0), 5'd2, 1'b0};
        tv[3]  = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b1, slot(0), 5'd3, 1'b0};
        tv[4]  = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b1, slot(0), 5'd4, 1'b0};
        tv[5]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, slot(0), 5'd3, 1'b0};
        tv[6]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, slot(0), 5'd2, 1'b0};
        tv[7]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, slot(0), 5'd1, 1'b0};
        tv[8]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, slot(0), 5'd0, 1'b0};
        tv[9]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, slot(0), 5'd0, 1'b0};
`else
        tv[1]  = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b1, slot(0), 5'd1, 1'b0};
        tv[2]  = '{1'b0, 4'hF, 1'b0, 4'h2, 1'b1, slot(1), 5'd2, 1'b0};
        tv[3]  = '{1'b0, 4'hF, 1'b0, 4'h4, 1'b1, slot(2), 5'd3, 1'b0};
        tv[4]  = '{1'b0, 4'hF, 1'b0, 4'h8, 1'b1, slot(3), 5'd4, 1'b0};
        tv[5]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, slot(3), 5'd3, 1'b0};
        tv[6]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, slot(3), 5'd2, 1'b0};
        tv[7]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, slot(3), 5'd1, 1'b0};
        tv[8]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, slot(3), 5'd0, 1'b0};
        tv[9]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, slot(3), 5'd0, 1'b0};
`endif
        tv[10] = '{1'b0, 4'h2, 1'b0, 4'h2, 1'b1, slot(1), 5'd1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            run_cycle(tv[i].rst, tv[i].req, tv[i].pop, tv[i].exp_gnt, tv[i].exp_push,
                      tv[i].exp_din, tv[i].exp_occ, tv[i].exp_full, $sformatf("vec%0d", i));
        end

        // Fill to depth: occupancy 1 -> 16 with all requesting and no pops.
        rst = 1'b0; req = 4'hF; pop = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #4;
            check("fill.gnt_nonzero", 32'(gnt != 4'h0), 32'd1);
            @(posedge clk); #1;
        end
        check("fill.occ", 32'(occupancy), 32'd16);
        check("fill.full", 32'(credit_full), 32'd1);

        // Full: requests held, no pop -> no grant, no push.
        run_cycle(1'b0, 4'hF, 1'b0, 4'h0, 1'b0, fifo_din, 5'd16, 1'b1, "full");

        // Full plus pop: blocked producer granted the same cycle.
        run_cycle(1'b0, 4'h4, 1'b1, 4'h4, 1'b1, slot(2), 5'd16, 1'b1, "fullpop");

        // Reset mid-operation drops state and the in-flight push.
        run_cycle(1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 32'h0, 5'd0, 1'b0, "midrst");

`ifdef FIFO_PUSH_ARB_FIXED_PRIO_EN
        run_cycle(1'b0, 4'h3, 1'b0, 4'h1, 1'b1, slot(0), 5'd1, 1'b0, "fix0");
        run_cycle(1'b0, 4'h3, 1'b0, 4'h1, 1'b1, slot(0), 5'd2, 1'b0, "fix1");
        run_cycle(1'b0, 4'h3, 1'b0, 4'h1, 1'b1, slot(0), 5'd3, 1'b0, "fix2");
`endif

        // Randomized traffic against the reference model.
        m_occ = 0; m_ptr = 0; m_push = 1'b0; m_din = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = (cyc == 0) || ($urandom_range(0, 99) == 0);
            req = 4'($urandom);
            pop = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++) din[i*B +: B] = $urandom;

            m_k = -1;
            if (!rst && (m_occ < D || pop)) begin
                for (int i = 0; i < N; i++) begin
                    if (m_k < 0 && req[(m_ptr + i) % N]) m_k = (m_ptr + i) % N;
                end
            end
            m_gnt = (m_k >= 0) ? 4'(1 << m_k) : 4'h0;

            #4;
            check("rnd.gnt", 32'(gnt), 32'(m_gnt));

            if (rst) begin
                m_occ = 0; m_ptr = 0; m_push = 1'b0; m_din = 32'h0;
            end else begin
                m_push = (m_k >= 0);
                if (m_k >= 0) begin
                    m_din = din[m_k*B +: B];
`ifndef FIFO_PUSH_ARB_FIXED_PRIO_EN
                    m_ptr = (m_k + 1) % N;
`endif
                end
                if (m_k >= 0 && !pop) m_occ = m_occ + 1;
                else if (m_k < 0 && pop && m_occ > 0) m_occ = m_occ - 1;
            end

            @(posedge clk); #1;
            check("rnd.push", 32'(fifo_push), 32'(m_push));
            check("rnd.din", fifo_din, m_din);
            check("rnd.occ", 32'(occupancy), 32'(m_occ));
            check("rnd.full", 32'(credit_full), 32'(m_occ == D));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
